// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   This is the fetch stage for the MIPS CPU. It holds the PC and drives the
//   word address of the instruction ROM, which has a combinational read. On
//   the same edge that advances the PC, it captures the returned word into
//   the IF/ID pipeline register.
//
//   The stage handles the following:
//     - Load-use stall.
//     - Redirect for jr, j and branch. Redirects are taken in that priority
//       order and flush IF/ID.
//     - Halt/resume through a two-state RUN/HALT machine.
//     - A retired-fetch counter.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rom_addr     ROM word address = pc[ADDR_W+1:2]
//   rom_data     ROM read data for rom_addr, same cycle
//   stall        hold PC and IF/ID
//   br_taken     branch redirect, target in br_target
//   j_taken      J/JAL redirect, target in j_target
//   jr_taken     JR/JALR redirect, target in jr_target
//   halt / go    enter / leave the HALT state
//   pc           current fetch PC
//   ifid_instr   latched instruction (0 when flushed)
//   ifid_pc4     latched fetch PC + 4
//   ifid_valid   ifid_instr holds a real instruction
//   halted       block is in HALT
//   fetch_count  number of instructions latched with valid = 1
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic              j_taken,
    input  logic [31:0]       j_target,
    input  logic              jr_taken,
    input  logic [31:0]       jr_target,
    input  logic              halt,
    input  logic              go,
    output logic [31:0]       pc,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_pc4, w_pc4_next;
    logic        r_valid, w_valid_next;
    logic [31:0] r_count, w_count_next;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Target bits [1:0] are always discarded because the PC stays word aligned.
    logic        w_unused;
    assign w_unused = &{1'b0, jr_target[1:0], j_target[1:0], br_target[1:0]};

    assign w_redirect = jr_taken | j_taken | br_taken;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target = {br_target[31:2], 2'b00};
        if (jr_taken)
            w_target = {jr_target[31:2], 2'b00};
        else if (j_taken)
            w_target = {j_target[31:2], 2'b00};
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_pc4_next   = r_pc4;
        w_valid_next = r_valid;
        w_count_next = r_count;
        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    // The redirect wins over both halt and stall. The word
                    // fetched from the old path is dropped, and ifid_pc4 keeps
                    // its value.
                    w_pc_next    = w_target;
                    w_instr_next = 32'd0;
                    w_valid_next = 1'b0;
                end else if (halt) begin
                    // halt also covers the case where go is high at the same time.
                    w_state_next = ST_HALT;
                    w_instr_next = 32'd0;
                    w_valid_next = 1'b0;
                end else if (!stall) begin
                    w_pc_next    = w_pc_plus4;
                    w_instr_next = rom_data;
                    w_pc4_next   = w_pc_plus4;
                    w_valid_next = 1'b1;
                    w_count_next = r_count + 32'd1;
                end
            end
            ST_HALT: begin
                // All state is frozen here. Fetch restarts from the held PC on
                // the edge after go.
                if (go)
                    w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_pc4   <= w_pc4_next;
            r_valid <= w_valid_next;
            r_count <= w_count_next;
        end
    end

    assign rom_addr    = r_pc[ADDR_W+1:2];
    assign pc          = r_pc;
    assign ifid_instr  = r_instr;
    assign ifid_pc4    = r_pc4;
    assign ifid_valid  = r_valid;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed testbench for instr_fetch. It holds a behavioural 1024-word ROM
//   with a combinational read. Each scenario lives in its own task and
//   compares the outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        stall, br_taken, j_taken, jr_taken, halt, go;
    logic [31:0] br_target, j_target, jr_target;
    logic [31:0] pc, ifid_instr, ifid_pc4, fetch_count;
    logic        ifid_valid, halted;

    logic [31:0] rom [1024];
    int tests_run;
    int tests_failed;

    instr_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .j_taken(j_taken), .j_target(j_target),
        .jr_taken(jr_taken), .jr_target(jr_target),
        .halt(halt), .go(go),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    // Wait for the next rising edge, then sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 0; br_taken = 0; j_taken = 0; jr_taken = 0; halt = 0; go = 0;
        br_target = 0; j_target = 0; jr_target = 0;
    endtask

    task automatic do_reset();
        clear_ctrl();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_ctrl();
        rst_n = 0;
        step();
        step();
        tests_run++;
        if (pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pc got %h want %h", pc, 32'h0);
        end
        tests_run++;
        if (rom_addr !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_rom_addr got %0d want 0", rom_addr);
        end
        tests_run++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ifid got v=%b i=%h p=%h want 0", ifid_valid, ifid_instr, ifid_pc4);
        end
        tests_run++;
        if (halted !== 1'b0 || fetch_count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_misc got halted=%b cnt=%0d want 0/0", halted, fetch_count);
        end
        $display("[TB] reset: pc=%h valid=%b cnt=%0d", pc, ifid_valid, fetch_count);
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'h11; exp_instr[1] = 32'h22;
        exp_instr[2] = 32'h33; exp_instr[3] = 32'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            $display("[TB] seq edge %0d: pc=%h instr=%h pc4=%h", i + 1, pc, ifid_instr, ifid_pc4);
            tests_run++;
            if (ifid_instr !== exp_instr[i] || ifid_pc4 !== 32'(4 * (i + 1)) || ifid_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL seq_%0d got i=%h p=%h v=%b want i=%h p=%h v=1",
                         i, ifid_instr, ifid_pc4, ifid_valid, exp_instr[i], 32'(4 * (i + 1)));
            end
        end
        tests_run++;
        if (pc !== 32'd16 || fetch_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL seq_end got pc=%h cnt=%0d want 10/4", pc, fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            $display("[TB] stall cycle %0d: pc=%h instr=%h cnt=%0d", i, pc, ifid_instr, fetch_count);
            tests_run++;
            if (pc !== 32'd8 || ifid_instr !== 32'h22 || ifid_valid !== 1'b1 ||
                ifid_pc4 !== 32'd8 || fetch_count !== 32'd2) begin
                tests_failed++;
                $display("FAIL stall_%0d got pc=%h i=%h v=%b p=%h cnt=%0d want 8/22/1/8/2",
                         i, pc, ifid_instr, ifid_valid, ifid_pc4, fetch_count);
            end
        end
        stall = 0;
        step();
        tests_run++;
        if (ifid_instr !== 32'h33 || pc !== 32'd12 || fetch_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL stall_resume got i=%h pc=%h cnt=%0d want 33/c/3", ifid_instr, pc, fetch_count);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        br_taken = 1;
        br_target = 32'h40;
        step();
        clear_ctrl();
        $display("[TB] branch: pc=%h valid=%b", pc, ifid_valid);
        tests_run++;
        if (pc !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || fetch_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL branch_bubble got pc=%h v=%b i=%h cnt=%0d want 40/0/0/4",
                     pc, ifid_valid, ifid_instr, fetch_count);
        end
        tests_run++;
        if (ifid_pc4 !== 32'h10) begin
            tests_failed++;
            $display("FAIL branch_pc4_hold got %h want 10", ifid_pc4);
        end
        step();
        tests_run++;
        if (ifid_instr !== 32'hA000_0010 || ifid_pc4 !== 32'h44 || ifid_valid !== 1'b1 ||
            fetch_count !== 32'd5) begin
            tests_failed++;
            $display("FAIL branch_target got i=%h p=%h v=%b cnt=%0d want a0000010/44/1/5",
                     ifid_instr, ifid_pc4, ifid_valid, fetch_count);
        end
    endtask

    task automatic test_priority();
        do_reset();
        step();
        jr_taken = 1; jr_target = 32'h81;
        j_taken  = 1; j_target  = 32'h200;
        br_taken = 1; br_target = 32'h20;
        stall = 1;
        step();
        $display("[TB] priority jr+j+br+stall: pc=%h valid=%b", pc, ifid_valid);
        tests_run++;
        if (pc !== 32'h80 || ifid_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_jr got pc=%h v=%b want 80/0", pc, ifid_valid);
        end
        jr_taken = 0;
        stall = 0;
        step();
        tests_run++;
        if (pc !== 32'h200 || ifid_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_j got pc=%h v=%b want 200/0", pc, ifid_valid);
        end
        j_taken = 0;
        halt = 1;
        step();
        clear_ctrl();
        tests_run++;
        if (pc !== 32'h20 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_br_over_halt got pc=%h halted=%b want 20/0", pc, halted);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        halt = 1;
        step();
        halt = 0;
        tests_run++;
        if (halted !== 1'b1 || pc !== 32'h0C || ifid_valid !== 1'b0 || fetch_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL halt_enter got h=%b pc=%h v=%b cnt=%0d want 1/c/0/3",
                     halted, pc, ifid_valid, fetch_count);
        end
        for (int i = 0; i < 5; i++) begin
            br_taken = (i % 2 == 0);
            br_target = 32'h40;
            stall = (i == 3);
            step();
            $display("[TB] halted cycle %0d: pc=%h halted=%b", i, pc, halted);
            tests_run++;
            if (halted !== 1'b1 || pc !== 32'h0C || ifid_valid !== 1'b0 || fetch_count !== 32'd3) begin
                tests_failed++;
                $display("FAIL halt_hold_%0d got h=%b pc=%h v=%b cnt=%0d want 1/c/0/3",
                         i, halted, pc, ifid_valid, fetch_count);
            end
        end
        clear_ctrl();
        go = 1;
        step();
        go = 0;
        tests_run++;
        if (halted !== 1'b0 || pc !== 32'h0C) begin
            tests_failed++;
            $display("FAIL halt_go got h=%b pc=%h want 0/c", halted, pc);
        end
        step();
        tests_run++;
        if (ifid_instr !== 32'h44 || ifid_valid !== 1'b1 || pc !== 32'h10 || fetch_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL halt_resume got i=%h v=%b pc=%h cnt=%0d want 44/1/10/4",
                     ifid_instr, ifid_valid, pc, fetch_count);
        end
        go = 1;
        step();
        go = 0;
        tests_run++;
        if (halted !== 1'b0 || pc !== 32'h14) begin
            tests_failed++;
            $display("FAIL go_in_run got h=%b pc=%h want 0/14", halted, pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        jr_taken = 1;
        jr_target = 32'h0000_0FFC;
        step();
        clear_ctrl();
        tests_run++;
        if (rom_addr !== 10'd1023) begin
            tests_failed++;
            $display("FAIL wrap_addr_hi got %0d want 1023", rom_addr);
        end
        step();
        tests_run++;
        if (pc !== 32'h1000 || rom_addr !== 10'd0 || ifid_instr !== 32'hA000_03FF) begin
            tests_failed++;
            $display("FAIL wrap_addr got pc=%h a=%0d i=%h want 1000/0/a00003ff", pc, rom_addr, ifid_instr);
        end
        j_taken = 1;
        j_target = 32'hFFFF_FFFE;
        step();
        clear_ctrl();
        step();
        $display("[TB] pc wrap: pc=%h pc4=%h", pc, ifid_pc4);
        tests_run++;
        if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_pc got pc=%h p=%h v=%b want 0/0/1", pc, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 64; i++) step();
        tests_run++;
        if (pc !== 32'h100 || fetch_count !== 32'd64) begin
            tests_failed++;
            $display("FAIL pre_async got pc=%h cnt=%0d want 100/64", pc, fetch_count);
        end
        halt = 1;
        #2;
        rst_n = 0;
        #1;
        $display("[TB] async reset: pc=%h cnt=%0d valid=%b halted=%b", pc, fetch_count, ifid_valid, halted);
        tests_run++;
        if (pc !== 32'h0 || fetch_count !== 32'h0 || ifid_valid !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got pc=%h cnt=%0d v=%b h=%b want 0/0/0/0",
                     pc, fetch_count, ifid_valid, halted);
        end
        step();
        clear_ctrl();
        rst_n = 1;
        step();
        tests_run++;
        if (halted !== 1'b0 || ifid_instr !== 32'h11 || fetch_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL post_async got h=%b i=%h cnt=%0d want 0/11/1", halted, ifid_instr, fetch_count);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 1024; i++)
            rom[i] = (i < 4) ? 32'(32'h11 * (i + 1)) : (32'hA000_0000 | 32'(i));
        rst_n = 0;
        clear_ctrl();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_priority();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
